// File: rtl/branch_predictor.sv
// Bimodal 2-bit direction table plus tagged BTB for fetch-side prediction.
// Execute resolves branches; a registered mispredict pulse carries the redirect PC.
module branch_predictor #(
   parameter int XLEN    = 64,
   parameter int ENTRIES = 64,
   parameter int TAG_W   = 12
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   output logic            ready_o,
   input  logic            lookup_valid_i,
   input  logic [XLEN-1:0] lookup_pc_i,
   output logic            pred_valid_o,
   output logic            pred_taken_o,
   output logic [XLEN-1:0] pred_target_o,
   input  logic            upd_valid_i,
   input  logic            upd_is_b_type_i,
   input  logic [XLEN-1:0] upd_pc_i,
   input  logic            upd_taken_i,
   input  logic [XLEN-1:0] upd_target_i,
   input  logic            upd_pred_taken_i,
   input  logic [XLEN-1:0] upd_pred_target_i,
   output logic            mispredict_o,
   output logic [XLEN-1:0] redirect_pc_o
);

   localparam int IDX_W = $clog2(ENTRIES);

   typedef enum logic {
      INIT,
      RUN
   } state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_cnt_q, idx_cnt_d;

   logic [1:0]       cnt_q   [ENTRIES];
   logic [1:0]       cnt_d   [ENTRIES];
   logic             btb_v_q [ENTRIES];
   logic             btb_v_d [ENTRIES];
   logic [TAG_W-1:0] btb_tag_q [ENTRIES];
   logic [TAG_W-1:0] btb_tag_d [ENTRIES];
   logic [XLEN-1:0]  btb_tgt_q [ENTRIES];
   logic [XLEN-1:0]  btb_tgt_d [ENTRIES];

   logic             pred_valid_q, pred_valid_d;
   logic             pred_taken_q, pred_taken_d;
   logic [XLEN-1:0]  pred_target_q, pred_target_d;
   logic             mispredict_q, mispredict_d;
   logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;

   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;
   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             up_en;
   logic             up_wrong;

   assign lk_idx = lookup_pc_i[IDX_W+1:2];
   assign lk_tag = lookup_pc_i[IDX_W+2 +: TAG_W];
   assign up_idx = upd_pc_i[IDX_W+1:2];
   assign up_tag = upd_pc_i[IDX_W+2 +: TAG_W];

   assign lk_hit = cnt_q[lk_idx][1] & btb_v_q[lk_idx]
                 & (btb_tag_q[lk_idx] == lk_tag);

   assign up_en = (state_q == RUN) & upd_valid_i & upd_is_b_type_i;

   assign up_wrong = (upd_taken_i != upd_pred_taken_i)
                   | (upd_taken_i & upd_pred_taken_i
                      & (upd_target_i != upd_pred_target_i));

   always_comb begin
      state_d       = state_q;
      idx_cnt_d     = idx_cnt_q;
      cnt_d         = cnt_q;
      btb_v_d       = btb_v_q;
      btb_tag_d     = btb_tag_q;
      btb_tgt_d     = btb_tgt_q;
      pred_valid_d  = 1'b0;
      pred_taken_d  = 1'b0;
      pred_target_d = pred_target_q;
      mispredict_d  = 1'b0;
      redirect_pc_d = redirect_pc_q;

      case (state_q)
         INIT: begin
            cnt_d[idx_cnt_q]   = 2'b01;
            btb_v_d[idx_cnt_q] = 1'b0;
            idx_cnt_d          = idx_cnt_q + 1'b1;
            if (idx_cnt_q == IDX_W'(ENTRIES - 1)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // Lookup reads the _q tables, so a same-index update is not seen yet.
            if (lookup_valid_i) begin
               pred_valid_d  = 1'b1;
               pred_taken_d  = lk_hit;
               pred_target_d = lk_hit ? btb_tgt_q[lk_idx]
                                      : lookup_pc_i + XLEN'(4);
            end
            if (up_en) begin
               if (upd_taken_i) begin
                  if (cnt_q[up_idx] != 2'b11) begin
                     cnt_d[up_idx] = cnt_q[up_idx] + 2'b01;
                  end
                  btb_v_d[up_idx]   = 1'b1;
                  btb_tag_d[up_idx] = up_tag;
                  btb_tgt_d[up_idx] = upd_target_i;
               end else if (cnt_q[up_idx] != 2'b00) begin
                  cnt_d[up_idx] = cnt_q[up_idx] - 2'b01;
               end
               if (up_wrong) begin
                  mispredict_d  = 1'b1;
                  redirect_pc_d = upd_taken_i ? upd_target_i
                                              : upd_pc_i + XLEN'(4);
               end
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q       <= INIT;
         idx_cnt_q     <= '0;
         pred_valid_q  <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
         mispredict_q  <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         idx_cnt_q     <= idx_cnt_d;
         pred_valid_q  <= pred_valid_d;
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
         mispredict_q  <= mispredict_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   // Table storage has no reset: the INIT sweep clears it instead.
   always_ff @(posedge clk_i) begin
      cnt_q     <= cnt_d;
      btb_v_q   <= btb_v_d;
      btb_tag_q <= btb_tag_d;
      btb_tgt_q <= btb_tgt_d;
   end

   assign ready_o       = (state_q == RUN);
   assign pred_valid_o  = pred_valid_q;
   assign pred_taken_o  = pred_taken_q;
   assign pred_target_o = pred_target_q;
   assign mispredict_o  = mispredict_q;
   assign redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, collision/reset
// sequences, then random traffic against an array-based predictor model.
module tb_branch_predictor;

   localparam int N = 64;

   logic        clk = 1'b0;
   logic        rst_n_i;
   logic        ready_o;
   logic        lookup_valid_i;
   logic [63:0] lookup_pc_i;
   logic        pred_valid_o;
   logic        pred_taken_o;
   logic [63:0] pred_target_o;
   logic        upd_valid_i;
   logic        upd_is_b_type_i;
   logic [63:0] upd_pc_i;
   logic        upd_taken_i;
   logic [63:0] upd_target_i;
   logic        upd_pred_taken_i;
   logic [63:0] upd_pred_target_i;
   logic        mispredict_o;
   logic [63:0] redirect_pc_o;

   int total = 0;
   int bad   = 0;

   branch_predictor dut (
      .clk_i             (clk),
      .rst_n_i           (rst_n_i),
      .ready_o           (ready_o),
      .lookup_valid_i    (lookup_valid_i),
      .lookup_pc_i       (lookup_pc_i),
      .pred_valid_o      (pred_valid_o),
      .pred_taken_o      (pred_taken_o),
      .pred_target_o     (pred_target_o),
      .upd_valid_i       (upd_valid_i),
      .upd_is_b_type_i   (upd_is_b_type_i),
      .upd_pc_i          (upd_pc_i),
      .upd_taken_i       (upd_taken_i),
      .upd_target_i      (upd_target_i),
      .upd_pred_taken_i  (upd_pred_taken_i),
      .upd_pred_target_i (upd_pred_target_i),
      .mispredict_o      (mispredict_o),
      .redirect_pc_o     (redirect_pc_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_up;
      logic [63:0] pc;
      bit          b;
      bit          tk;
      logic [63:0] tgt;
      bit          ptk;
      logic [63:0] ptgt;
      bit          e_bit;
      logic [63:0] e_val;
   } vec_t;

   vec_t vq[$];

   int          m_cnt [N];
   bit          m_v   [N];
   int          m_tag [N];
   logic [63:0] m_tgt [N];
   logic [63:0] m_red;

   function automatic vec_t lk(logic [63:0] pc, bit et, logic [63:0] eg);
      vec_t v;
      v = '{0, pc, 0, 0, 64'd0, 0, 64'd0, et, eg};
      return v;
   endfunction

   function automatic vec_t up(logic [63:0] pc, bit b, bit tk,
                               logic [63:0] tgt, bit ptk,
                               logic [63:0] ptgt, bit em,
                               logic [63:0] er);
      vec_t v;
      v = '{1, pc, b, tk, tgt, ptk, ptgt, em, er};
      return v;
   endfunction

   function automatic int midx(logic [63:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic int mtag(logic [63:0] pc);
      return int'((pc >> 8) % 4096);
   endfunction

   function automatic bit mpred(logic [63:0] pc);
      int i;
      i = midx(pc);
      return (m_cnt[i] >= 2) && m_v[i] && (m_tag[i] == mtag(pc));
   endfunction

   task automatic model_init();
      for (int i = 0; i < N; i++) begin
         m_cnt[i] = 1;
         m_v[i]   = 0;
      end
      m_red = 64'd0;
   endtask

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      lookup_valid_i    = 0;
      lookup_pc_i       = 64'd0;
      upd_valid_i       = 0;
      upd_is_b_type_i   = 0;
      upd_pc_i          = 64'd0;
      upd_taken_i       = 0;
      upd_target_i      = 64'd0;
      upd_pred_taken_i  = 0;
      upd_pred_target_i = 64'd0;
   endtask

   task automatic do_lookup(logic [63:0] pc, bit et, logic [63:0] eg,
                            string nm);
      lookup_valid_i = 1;
      lookup_pc_i    = pc;
      step();
      lookup_valid_i = 0;
      chk({nm, ".valid"}, 64'(pred_valid_o), 64'd1);
      chk({nm, ".taken"}, 64'(pred_taken_o), 64'(et));
      chk({nm, ".target"}, pred_target_o, eg);
   endtask

   // Counts cycles until ready; optional noise checks INIT ignores traffic.
   task automatic wait_ready(bit noise);
      int n;
      n = 0;
      if (noise) begin
         lookup_valid_i    = 1;
         lookup_pc_i       = 64'h1000;
         upd_valid_i       = 1;
         upd_is_b_type_i   = 1;
         upd_pc_i          = 64'h1000;
         upd_taken_i       = 1;
         upd_target_i      = 64'h9000;
         upd_pred_taken_i  = 0;
      end
      while (!ready_o && n < 200) begin
         step();
         n++;
         if (noise) begin
            chk("init.pred_valid", 64'(pred_valid_o), 64'd0);
            chk("init.mispredict", 64'(mispredict_o), 64'd0);
         end
      end
      idle_inputs();
      chk("init.cycles", 64'(n), 64'd64);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      bit lv, uv, ub, utk, ptk, ept, emis;
      logic [63:0] lpc, upc, utgt, ptgt, etgt;
      logic [11:0] pool [4];
      bit          sv_v [N];
      int          sv_t [N];
      logic [63:0] p;

      idle_inputs();
      rst_n_i = 0;
      repeat (3) step();
      chk("rst.ready", 64'(ready_o), 64'd0);
      chk("rst.pred_valid", 64'(pred_valid_o), 64'd0);
      chk("rst.pred_taken", 64'(pred_taken_o), 64'd0);
      chk("rst.pred_target", pred_target_o, 64'd0);
      chk("rst.mispredict", 64'(mispredict_o), 64'd0);
      chk("rst.redirect", redirect_pc_o, 64'd0);
      rst_n_i = 1;
      wait_ready(1);

      vq.push_back(lk(64'h1000, 0, 64'h1004));
      vq.push_back(up(64'h1000, 1, 1, 64'h2000, 0, 64'h0, 1, 64'h2000));
      vq.push_back(lk(64'h1000, 1, 64'h2000));
      vq.push_back(up(64'h1000, 1, 1, 64'h2000, 1, 64'h2000, 0, 64'h2000));
      vq.push_back(lk(64'h1000, 1, 64'h2000));
      vq.push_back(up(64'h1000, 1, 0, 64'h0, 1, 64'h2000, 1, 64'h1004));
      vq.push_back(lk(64'h1000, 1, 64'h2000));
      vq.push_back(up(64'h1000, 1, 0, 64'h0, 0, 64'h0, 0, 64'h1004));
      vq.push_back(up(64'h1000, 1, 0, 64'h0, 0, 64'h0, 0, 64'h1004));
      vq.push_back(lk(64'h1000, 0, 64'h1004));
      vq.push_back(up(64'h1000, 1, 0, 64'h0, 0, 64'h0, 0, 64'h1004));
      vq.push_back(up(64'h1000, 1, 1, 64'h2000, 0, 64'h0, 1, 64'h2000));
      vq.push_back(lk(64'h1000, 0, 64'h1004));
      vq.push_back(up(64'h1000, 1, 1, 64'h2000, 0, 64'h0, 1, 64'h2000));
      vq.push_back(lk(64'h1000, 1, 64'h2000));
      vq.push_back(lk(64'h1100, 0, 64'h1104));
      vq.push_back(up(64'h3000, 1, 1, 64'h3400, 0, 64'h0, 1, 64'h3400));
      vq.push_back(up(64'h3000, 1, 0, 64'h0, 1, 64'h3400, 1, 64'h3004));
      vq.push_back(up(64'h3000, 1, 1, 64'h3400, 1, 64'h3500, 1, 64'h3400));
      vq.push_back(up(64'h3000, 0, 1, 64'h5000, 0, 64'h0, 0, 64'h3400));
      vq.push_back(lk(64'h3000, 1, 64'h3400));
      vq.push_back(lk(64'h1000, 0, 64'h1004));
      vq.push_back(lk(64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0));
      vq.push_back(lk(64'h3002, 1, 64'h3400));

      foreach (vq[k]) begin
         v = vq[k];
         if (v.is_up) begin
            upd_valid_i       = 1;
            upd_is_b_type_i   = v.b;
            upd_pc_i          = v.pc;
            upd_taken_i       = v.tk;
            upd_target_i      = v.tgt;
            upd_pred_taken_i  = v.ptk;
            upd_pred_target_i = v.ptgt;
            step();
            idle_inputs();
            chk($sformatf("vec%0d.mispredict", k), 64'(mispredict_o),
                64'(v.e_bit));
            chk($sformatf("vec%0d.redirect", k), redirect_pc_o, v.e_val);
            chk($sformatf("vec%0d.no_pred", k), 64'(pred_valid_o), 64'd0);
         end else begin
            do_lookup(v.pc, v.e_bit, v.e_val, $sformatf("vec%0d", k));
            chk($sformatf("vec%0d.no_mis", k), 64'(mispredict_o), 64'd0);
         end
      end

      step();
      chk("idle.pred_valid", 64'(pred_valid_o), 64'd0);
      chk("idle.pred_taken", 64'(pred_taken_o), 64'd0);

      lookup_valid_i   = 1;
      lookup_pc_i      = 64'h1014;
      upd_valid_i      = 1;
      upd_is_b_type_i  = 1;
      upd_pc_i         = 64'h1014;
      upd_taken_i      = 1;
      upd_target_i     = 64'h7000;
      upd_pred_taken_i = 0;
      step();
      idle_inputs();
      chk("coll.old_taken", 64'(pred_taken_o), 64'd0);
      chk("coll.old_target", pred_target_o, 64'h1018);
      chk("coll.mispredict", 64'(mispredict_o), 64'd1);
      chk("coll.redirect", redirect_pc_o, 64'h7000);
      do_lookup(64'h1014, 1, 64'h7000, "coll.new");

      rst_n_i = 0;
      step();
      chk("midrst.ready", 64'(ready_o), 64'd0);
      chk("midrst.redirect", redirect_pc_o, 64'd0);
      rst_n_i = 1;
      wait_ready(0);
      model_init();
      do_lookup(64'h1014, 0, 64'h1018, "midrst.l1");
      do_lookup(64'h3000, 0, 64'h3004, "midrst.l2");

      pool[0] = 12'h010;
      pool[1] = 12'h011;
      pool[2] = 12'hABC;
      pool[3] = 12'hFFF;
      for (int c = 0; c < 1500; c++) begin
         lv = 1'($urandom_range(0, 1));
         lpc = {$urandom, $urandom};
         lpc[19:8] = pool[$urandom_range(0, 3)];
         lpc[7:6] = 2'b00;
         uv = ($urandom_range(0, 3) != 0);
         ub = ($urandom_range(0, 4) != 0);
         upc = {$urandom, $urandom};
         upc[19:8] = pool[$urandom_range(0, 3)];
         upc[7:6] = 2'b00;
         utk = 1'($urandom_range(0, 1));
         utgt = {$urandom, $urandom} & ~64'h3;
         ptk = $urandom_range(0, 1) ? mpred(upc) : 1'($urandom_range(0, 1));
         ptgt = $urandom_range(0, 1) ? utgt : ({$urandom, $urandom} & ~64'h3);

         ept = lv && mpred(lpc);
         etgt = ept ? m_tgt[midx(lpc)] : lpc + 64'd4;
         emis = uv && ub && ((utk != ptk) || (utk && ptk && utgt != ptgt));
         if (emis) m_red = utk ? utgt : upc + 64'd4;
         if (uv && ub) begin
            if (utk) begin
               m_cnt[midx(upc)] = (m_cnt[midx(upc)] + 1 > 3) ? 3
                                  : m_cnt[midx(upc)] + 1;
               m_v[midx(upc)]   = 1;
               m_tag[midx(upc)] = mtag(upc);
               m_tgt[midx(upc)] = utgt;
            end else begin
               m_cnt[midx(upc)] = (m_cnt[midx(upc)] - 1 < 0) ? 0
                                  : m_cnt[midx(upc)] - 1;
            end
         end

         lookup_valid_i    = lv;
         lookup_pc_i       = lpc;
         upd_valid_i       = uv;
         upd_is_b_type_i   = ub;
         upd_pc_i          = upc;
         upd_taken_i       = utk;
         upd_target_i      = utgt;
         upd_pred_taken_i  = ptk;
         upd_pred_target_i = ptgt;
         step();
         chk("rnd.pred_valid", 64'(pred_valid_o), 64'(lv));
         chk("rnd.pred_taken", 64'(pred_taken_o), 64'(ept));
         if (lv) chk("rnd.pred_target", pred_target_o, etgt);
         chk("rnd.mispredict", 64'(mispredict_o), 64'(emis));
         chk("rnd.redirect", redirect_pc_o, m_red);
      end
      idle_inputs();

      for (int i = 0; i < N; i++) begin
         sv_v[i] = m_v[i];
         sv_t[i] = m_tag[i];
      end
      rst_n_i = 0;
      step();
      rst_n_i = 1;
      wait_ready(0);
      model_init();
      for (int i = 0; i < N; i++) begin
         if (sv_v[i]) begin
            p = (64'(sv_t[i]) << 8) | (64'(i) << 2);
            do_lookup(p, 0, p + 64'd4, $sformatf("clear%0d", i));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
